// File: rtl/controlpath_seq_if.sv
// Instruction-fetch channel between the instruction source/decoder and the sequencer.
// The source drives the instruction word together with the decoder's same-cycle verdict and write mask.
interface controlpath_seq_if #(
    parameter int INSTR_W = 32,
    parameter int N_WR    = 2
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic               decode_invalid;
    logic [N_WR-1:0]    decode_wmask;

    modport master (
        output instr_valid,
        output instruction,
        output decode_invalid,
        output decode_wmask,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instruction,
        input  decode_invalid,
        input  decode_wmask,
        output instr_ready
    );
endinterface

// File: rtl/controlpath_seq.sv
// Multi-cycle fetch/exec/writeback sequencer with single-step, halt/resume,
// invalid-instruction stop and a saturating retired-instruction counter.
//
// state   | meaning
// IDLE    | waiting for start (or halt_req)
// FETCH   | instr_ready high, waiting for an instruction handshake
// EXEC    | alu_en high for ALU_LAT cycles
// WB      | single cycle: alu_write pulse, pc and retired advance at its end
// STOPPED | halted or invalid instruction seen; resume returns to IDLE
module controlpath_seq #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 16,
    parameter int PC_STEP = 1,
    parameter int ALU_LAT = 2,
    parameter int N_WR    = 2,
    parameter int RET_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    controlpath_seq_if.slave   fetch,
    input  logic               start,
    input  logic               step_mode,
    input  logic               halt_req,
    input  logic               resume,
    output logic [INSTR_W-1:0] ir,
    output logic               alu_en,
    output logic [N_WR-1:0]    alu_write,
    output logic [PC_W-1:0]    pc,
    output logic               pc_inc,
    output logic [3:0]         state,
    output logic               stopped,
    output logic               err_invalid,
    output logic [RET_W-1:0]   retired
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'b0000,
        S_FETCH   = 4'b0001,
        S_EXEC    = 4'b0010,
        S_WB      = 4'b0100,
        S_STOPPED = 4'b1000
    } state_t;

    localparam int                LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(ALU_LAT - 1);
    localparam logic [PC_W-1:0]   PC_ADD   = PC_W'(PC_STEP);
    localparam logic [RET_W-1:0]  RET_MAX  = '1;

    state_t            st;
    logic              halt_pend;
    logic [LAT_W-1:0]  lat_cnt;
    logic [N_WR-1:0]   wmask;
    logic              handshake;
    logic              halt_now;

    assign handshake = fetch.instr_valid & fetch.instr_ready;
    assign halt_now  = halt_pend | halt_req;
    assign state     = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st                <= S_IDLE;
            halt_pend         <= 1'b0;
            lat_cnt           <= '0;
            wmask             <= '0;
            ir                <= '0;
            pc                <= '0;
            retired           <= '0;
            fetch.instr_ready <= 1'b0;
            alu_en            <= 1'b0;
            alu_write         <= '0;
            pc_inc            <= 1'b0;
            stopped           <= 1'b0;
            err_invalid       <= 1'b0;
        end else begin
            alu_write <= '0;
            pc_inc    <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (halt_req) begin
                        st      <= S_STOPPED;
                        stopped <= 1'b1;
                    end else if (start) begin
                        st                <= S_FETCH;
                        fetch.instr_ready <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (handshake) begin
                        fetch.instr_ready <= 1'b0;
                        halt_pend         <= halt_now;
                        if (fetch.decode_invalid) begin
                            st          <= S_STOPPED;
                            stopped     <= 1'b1;
                            err_invalid <= 1'b1;
                        end else begin
                            ir      <= fetch.instruction;
                            wmask   <= fetch.decode_wmask;
                            lat_cnt <= LAT_INIT;
                            alu_en  <= 1'b1;
                            st      <= S_EXEC;
                        end
                    end else if (halt_now) begin
                        // no instruction in flight, so the halt takes effect right here
                        fetch.instr_ready <= 1'b0;
                        halt_pend         <= 1'b1;
                        stopped           <= 1'b1;
                        st                <= S_STOPPED;
                    end
                end
                S_EXEC: begin
                    halt_pend <= halt_now;
                    if (lat_cnt == '0) begin
                        alu_en    <= 1'b0;
                        alu_write <= wmask;
                        pc_inc    <= 1'b1;
                        st        <= S_WB;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_WB: begin
                    pc <= pc + PC_ADD;
                    if (retired != RET_MAX) retired <= retired + RET_W'(1);
                    if (halt_now) begin
                        halt_pend <= 1'b1;
                        stopped   <= 1'b1;
                        st        <= S_STOPPED;
                    end else if (step_mode) begin
                        st <= S_IDLE;
                    end else begin
                        fetch.instr_ready <= 1'b1;
                        st                <= S_FETCH;
                    end
                end
                S_STOPPED: begin
                    if (resume) begin
                        stopped     <= 1'b0;
                        err_invalid <= 1'b0;
                        halt_pend   <= 1'b0;
                        st          <= S_IDLE;
                    end
                end
                default: begin
                    st                <= S_IDLE;
                    fetch.instr_ready <= 1'b0;
                    alu_en            <= 1'b0;
                    stopped           <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_controlpath_seq.sv
// Directed bench for controlpath_seq (PC_W=4, RET_W=4, ALU_LAT=2) with hand-computed expectations.
module tb_controlpath_seq;
    localparam int INSTR_W = 32;
    localparam int N_WR    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, step_mode, halt_req, resume;
    logic [INSTR_W-1:0] ir;
    logic               alu_en;
    logic [N_WR-1:0]    alu_write;
    logic [3:0]         pc;
    logic               pc_inc;
    logic [3:0]         state;
    logic               stopped;
    logic               err_invalid;
    logic [3:0]         retired;

    int total = 0;
    int bad   = 0;

    controlpath_seq_if #(.INSTR_W(INSTR_W), .N_WR(N_WR)) bus ();

    controlpath_seq #(
        .INSTR_W(INSTR_W), .PC_W(4), .PC_STEP(1), .ALU_LAT(2), .N_WR(N_WR), .RET_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch(bus),
        .start(start), .step_mode(step_mode), .halt_req(halt_req), .resume(resume),
        .ir(ir), .alu_en(alu_en), .alu_write(alu_write), .pc(pc), .pc_inc(pc_inc),
        .state(state), .stopped(stopped), .err_invalid(err_invalid), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 0; step_mode = 0; halt_req = 0; resume = 0;
        bus.instr_valid = 0; bus.instruction = '0; bus.decode_invalid = 0; bus.decode_wmask = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (state !== 4'b0000) begin bad++; $display("FAIL reset_state got=%b exp=0000", state); end
        total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        total++; if (ir !== 32'd0) begin bad++; $display("FAIL reset_ir got=%h exp=0", ir); end
        total++; if (retired !== 4'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        total++; if ({bus.instr_ready, alu_en, alu_write, pc_inc, stopped, err_invalid} !== 7'b0)
            begin bad++; $display("FAIL reset_outputs got=%b exp=0000000",
                {bus.instr_ready, alu_en, alu_write, pc_inc, stopped, err_invalid}); end
    endtask

    task automatic test_continuous();
        logic [31:0] instr;
        logic [1:0]  wm;
        do_reset();
        pulse_start();
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = 32'hA000_0100 + 32'(i);
            wm    = 2'(i + 1);
            bus.instruction = instr; bus.decode_wmask = wm;
            total++; if (state !== 4'b0001 || bus.instr_ready !== 1'b1)
                begin bad++; $display("FAIL cont_fetch[%0d] got=%b/%b exp=0001/1", i, state, bus.instr_ready); end
            total++; if (pc !== 4'(i)) begin bad++; $display("FAIL cont_pc_pre[%0d] got=%0d exp=%0d", i, pc, i); end
            tick();
            bus.decode_wmask = 2'b00;
            total++; if (state !== 4'b0010 || alu_en !== 1'b1 || ir !== instr)
                begin bad++; $display("FAIL cont_exec1[%0d] got=%b/%b/%h exp=0010/1/%h", i, state, alu_en, ir, instr); end
            total++; if (alu_write !== 2'b00) begin bad++; $display("FAIL cont_exec_wr[%0d] got=%b exp=00", i, alu_write); end
            tick();
            total++; if (state !== 4'b0010 || alu_en !== 1'b1)
                begin bad++; $display("FAIL cont_exec2[%0d] got=%b/%b exp=0010/1", i, state, alu_en); end
            tick();
            total++; if (state !== 4'b0100 || alu_write !== wm || pc_inc !== 1'b1 || alu_en !== 1'b0)
                begin bad++; $display("FAIL cont_wb[%0d] got=%b/%b/%b exp=0100/%b/1", i, state, alu_write, pc_inc, wm); end
            tick();
            total++; if (pc !== 4'(i + 1) || retired !== 4'(i + 1) || alu_write !== 2'b00)
                begin bad++; $display("FAIL cont_post[%0d] got pc=%0d ret=%0d wr=%b exp pc=%0d ret=%0d wr=00",
                    i, pc, retired, alu_write, i + 1, i + 1); end
        end
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1;
        bus.instr_valid = 1'b1; bus.instruction = 32'h0000_5555; bus.decode_wmask = 2'b10;
        for (int k = 1; k <= 2; k++) begin
            pulse_start();
            repeat (4) tick();
            total++; if (state !== 4'b0000 || pc !== 4'(k) || retired !== 4'(k))
                begin bad++; $display("FAIL step_idle[%0d] got st=%b pc=%0d ret=%0d exp st=0000 pc=%0d ret=%0d",
                    k, state, pc, retired, k, k); end
            repeat (3) tick();
            total++; if (state !== 4'b0000 || bus.instr_ready !== 1'b0 || pc !== 4'(k))
                begin bad++; $display("FAIL step_hold[%0d] got st=%b rdy=%b pc=%0d exp 0000/0/%0d", k, state, bus.instr_ready, pc, k); end
        end
    endtask

    task automatic test_invalid();
        do_reset();
        pulse_start();
        bus.instr_valid = 1'b1; bus.instruction = 32'h1111_0001; bus.decode_wmask = 2'b11;
        repeat (4) tick();
        bus.instruction = 32'hDEAD_BEEF; bus.decode_invalid = 1'b1;
        tick();
        bus.instr_valid = 1'b0; bus.decode_invalid = 1'b0;
        total++; if (state !== 4'b1000 || stopped !== 1'b1 || err_invalid !== 1'b1)
            begin bad++; $display("FAIL inv_stop got st=%b stp=%b err=%b exp 1000/1/1", state, stopped, err_invalid); end
        total++; if (pc !== 4'd1 || retired !== 4'd1 || ir !== 32'h1111_0001)
            begin bad++; $display("FAIL inv_hold got pc=%0d ret=%0d ir=%h exp 1/1/11110001", pc, retired, ir); end
        for (int c = 0; c < 4; c++) begin
            total++; if (alu_write !== 2'b00 || alu_en !== 1'b0 || bus.instr_ready !== 1'b0)
                begin bad++; $display("FAIL inv_quiet[%0d] got wr=%b en=%b rdy=%b exp 00/0/0", c, alu_write, alu_en, bus.instr_ready); end
            tick();
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++; if (state !== 4'b0000 || err_invalid !== 1'b0 || stopped !== 1'b0)
            begin bad++; $display("FAIL inv_resume got st=%b err=%b stp=%b exp 0000/0/0", state, err_invalid, stopped); end
    endtask

    task automatic test_halt();
        do_reset();
        pulse_start();
        bus.instr_valid = 1'b1; bus.instruction = 32'h2222_0002; bus.decode_wmask = 2'b11;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        total++; if (state !== 4'b0010) begin bad++; $display("FAIL halt_exec got=%b exp=0010", state); end
        tick();
        total++; if (state !== 4'b0100 || alu_write !== 2'b11 || pc_inc !== 1'b1)
            begin bad++; $display("FAIL halt_wb got st=%b wr=%b inc=%b exp 0100/11/1", state, alu_write, pc_inc); end
        tick();
        total++; if (state !== 4'b1000 || stopped !== 1'b1 || pc !== 4'd1 || retired !== 4'd1 || err_invalid !== 1'b0)
            begin bad++; $display("FAIL halt_stop got st=%b stp=%b pc=%0d ret=%0d err=%b exp 1000/1/1/1/0",
                state, stopped, pc, retired, err_invalid); end
        repeat (3) tick();
        total++; if (state !== 4'b1000 || retired !== 4'd1 || bus.instr_ready !== 1'b0)
            begin bad++; $display("FAIL halt_hold got st=%b ret=%0d rdy=%b exp 1000/1/0", state, retired, bus.instr_ready); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++; if (state !== 4'b0000) begin bad++; $display("FAIL halt_resume got=%b exp=0000", state); end
        halt_req = 1'b1; start = 1'b1;
        tick();
        halt_req = 1'b0; start = 1'b0;
        total++; if (state !== 4'b1000 || stopped !== 1'b1)
            begin bad++; $display("FAIL halt_vs_start got st=%b stp=%b exp 1000/1", state, stopped); end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        pulse_start();
        bus.instr_valid = 1'b1; bus.instruction = 32'h3333_0003; bus.decode_wmask = 2'b01;
        for (int n = 1; n <= 17; n++) begin
            repeat (4) tick();
            if (n == 15) begin
                total++; if (pc !== 4'd15 || retired !== 4'd15)
                    begin bad++; $display("FAIL wrap_15 got pc=%0d ret=%0d exp 15/15", pc, retired); end
            end
            if (n == 16) begin
                total++; if (pc !== 4'd0 || retired !== 4'd15)
                    begin bad++; $display("FAIL wrap_16 got pc=%0d ret=%0d exp 0/15", pc, retired); end
            end
            if (n == 17) begin
                total++; if (pc !== 4'd1 || retired !== 4'd15)
                    begin bad++; $display("FAIL wrap_17 got pc=%0d ret=%0d exp 1/15", pc, retired); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        do_reset();
        pulse_start();
        bus.instr_valid = 1'b1; bus.instruction = 32'h4444_0004; bus.decode_wmask = 2'b10;
        repeat (5) tick();
        total++; if (state !== 4'b0010 || pc !== 4'd1)
            begin bad++; $display("FAIL rmid_pre got st=%b pc=%0d exp 0010/1", state, pc); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (state !== 4'b0000 || pc !== 4'd0 || alu_en !== 1'b0 || alu_write !== 2'b00 || retired !== 4'd0)
            begin bad++; $display("FAIL rmid_async got st=%b pc=%0d en=%b wr=%b ret=%0d exp 0000/0/0/00/0",
                state, pc, alu_en, alu_write, retired); end
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr_seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (alu_write !== 2'b00 || state !== 4'b0000) wr_seen++;
        end
        total++; if (wr_seen !== 0) begin bad++; $display("FAIL rmid_after got=%0d bad cycles exp=0", wr_seen); end
    endtask

    task automatic test_fetch_hold();
        do_reset();
        pulse_start();
        bus.instr_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (state !== 4'b0001 || bus.instr_ready !== 1'b1 || alu_en !== 1'b0)
                begin bad++; $display("FAIL fetch_hold[%0d] got st=%b rdy=%b en=%b exp 0001/1/0", c, state, bus.instr_ready, alu_en); end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_step();
        test_invalid();
        test_halt();
        test_wrap_saturate();
        test_reset_mid();
        test_fetch_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controlpath_seq.md
Name: controlpath_seq

Overview:
Parametrised multi-cycle sequencer for the datapath control unit. It fetches instructions over a valid/ready handshake and holds each accepted instruction in an instruction register for the decoder. It runs the ALU for a configurable latency, then pulses register-file write enables and advances the program counter. It adds single-step, external halt/resume, a synchronous stop on invalid instructions, and a retired-instruction counter.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 16, program counter width; PC wraps modulo 2^PC_W
PC_STEP, 1, PC increment per retired instruction
ALU_LAT, 2, cycles spent in EXEC; must be >= 1
N_WR, 2, number of ALU write ports; one alu_write bit per port
RET_W, 16, retired counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; leaves IDLE
step_mode  in  1  1: return to IDLE after each retire; 0: run continuously
halt_req  in  1  request to stop at the next instruction boundary
resume  in  1  single-cycle pulse; leaves STOPPED
instr_valid  in  1  instruction source has data
instruction  in  INSTR_W  instruction word
instr_ready  out  1  sequencer accepts an instruction
decode_invalid  in  1  decoder verdict on `instruction`, same cycle
decode_wmask  in  N_WR  decoder write-port mask for `instruction`
ir  out  INSTR_W  latched instruction, drives the decoder in EXEC/WB
alu_en  out  1  ALU operands valid, high throughout EXEC
alu_write  out  N_WR  write-enable pulse, WB cycle only
pc  out  PC_W  program counter
pc_inc  out  1  high in the cycle pc is advanced
state  out  4  IDLE=0000, FETCH=0001, EXEC=0010, WB=0100, STOPPED=1000
stopped  out  1  state == STOPPED
err_invalid  out  1  sticky; set when an invalid instruction causes the stop
retired  out  RET_W  count of retired instructions, saturating

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; pc=0; ir=0; retired=0.
  - err_invalid=0; halt pending flag=0; all pulses and enables=0.
  - A reset mid-operation aborts the instruction immediately; no write pulse is produced.
- Registered Moore outputs; state is registered.
- IDLE:
  - halt_req=1 -> STOPPED.
  - Otherwise start=1 -> FETCH.
  - halt_req wins over a simultaneous start.
- FETCH:
  - instr_ready=1. The handshake completes when instr_valid & instr_ready.
  - On handshake with decode_invalid=1: -> STOPPED; err_invalid<=1; ir and pc unchanged; nothing retired.
  - On a valid handshake: ir<=instruction, wmask<=decode_wmask, latency counter<=ALU_LAT-1, -> EXEC.
  - With no instr_valid, FETCH holds indefinitely. A pending halt is honoured here: -> STOPPED without accepting an instruction.
- EXEC:
  - alu_en=1 for exactly ALU_LAT cycles.
  - The counter decrements each cycle; at 0 -> WB.
  - instr_ready=0.
- WB (exactly one cycle):
  - alu_write=wmask.
  - pc<=pc+PC_STEP, truncated to PC_W (wrap-around); pc_inc=1.
  - retired<=retired+1, saturating at 2^RET_W-1.
  - Next state:
    - halt pending -> STOPPED;
    - else step_mode=1 -> IDLE;
    - else -> FETCH.
- halt_req is captured into the pending flag in any cycle while in FETCH, EXEC or WB. An in-flight instruction always completes before the stop.
- STOPPED:
  - All enables=0; outputs hold.
  - resume=1 -> IDLE; clears err_invalid and the halt pending flag.
  - halt_req is ignored in STOPPED.
- Instruction latency: FETCH handshake to alu_write pulse is ALU_LAT+1 cycles.
- Continuous-run throughput: one instruction per ALU_LAT+2 cycles with instr_valid held high.

Test Plan:
1. Reset, start, instr_valid=1 with valid instructions, ALU_LAT=2, step_mode=0 -> states FETCH,EXEC,EXEC,WB repeat; alu_write=decode_wmask once per 4 cycles; pc=1,2,3; retired increments once per WB.
2. step_mode=1, start pulse -> exactly one instruction retired, pc=1, returns to IDLE; a second start retires the next (pc=2).
3. Second instruction has decode_invalid=1 -> STOPPED after its FETCH; err_invalid=1; pc=1; retired=1; no alu_write; a resume pulse -> IDLE with err_invalid=0.
4. halt_req pulse during EXEC -> WB still occurs (alu_write asserted, pc advances), then STOPPED; halt and start together in IDLE -> STOPPED.
5. PC_W=4, pc driven to 15 by retiring 15 instructions -> the next WB gives pc=0; RET_W=4 -> retired saturates at 15 after 16+ instructions.
6. rst_n low during EXEC -> immediate IDLE, pc=0, alu_en=0, no alu_write pulse; with instr_valid=0 in FETCH -> instr_ready stays 1 and state holds for 10 cycles.
